vga_timing_core: RTL and testbench
==================================

Name: vga_timing_core

Overview:
- Free-running VGA raster timing generator; top of the video pipeline.
- Produces pixel coordinates, sync pulses, a display-active flag and a frame counter.
- Its outputs drive the pattern/colour logic and the Tiny VGA Pmod pins.
- Frame counting runs synchronously in the clk domain, so downstream logic never clocks on a sync edge.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)
- FRAME_W, 9, width of frame counter

Ports:
- clk  in  1  pixel-rate clock (25.175 MHz nominal)
- rst_n  in  1  reset, synchronous, active-low
- pix_en  in  1  advance enable; raster holds when 0
- hpos  out  10  current column, 0..H_TOTAL-1
- vpos  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per SYNC_ACTIVE
- vsync  out  1  vertical sync, polarity per SYNC_ACTIVE
- display_on  out  1  high when hpos<H_DISPLAY and vpos<V_DISPLAY
- line_tick  out  1  one-cycle pulse on the first cycle of hpos=0
- frame_tick  out  1  one-cycle pulse on the first cycle of hpos=0, vpos=0
- frame_no  out  FRAME_W  frame counter

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- Reset (rst_n=0 at posedge clk):
  - hpos=0, vpos=0, frame_no=0
  - hsync=vsync=~SYNC_ACTIVE
  - display_on=1
  - line_tick=0, frame_tick=0
- pix_en=1 at posedge:
  - hpos increments, wrapping H_TOTAL-1 -> 0.
  - On that wrap, vpos increments, wrapping V_TOTAL-1 -> 0.
  - On a simultaneous h and v wrap, frame_no increments (mod 2^FRAME_W).
- pix_en=0: all counters and decoded outputs hold; line_tick and frame_tick forced 0.
- All outputs are registered.
  - hsync, vsync and display_on are decoded from the next hpos/vpos values, so they are cycle-aligned with the hpos/vpos presented in the same cycle. There is no pipeline skew between coordinates and flags.
- hsync asserted iff H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC (656..751).
- vsync asserted iff V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC (490..491). vsync is line-based: it changes only when hpos wraps to 0.
- line_tick:
  - Asserted for exactly one cycle, the cycle in which hpos first shows 0 after a wrap.
  - Not asserted after reset.
  - Not re-asserted while pix_en holds the raster at hpos=0.
- frame_tick: same rule as line_tick, qualified with vpos=0. frame_no already shows the new value in that cycle.
- frame_no wraps 2^FRAME_W-1 -> 0 with no flag.
- Reset mid-line or mid-frame: next cycle returns to the reset state regardless of pix_en. No partial sync pulse is extended; sync deasserts immediately.
- Counter widths are fixed at 10 bits. Parameter sets with H_TOTAL or V_TOTAL > 1024 are illegal; an elaboration-time check must flag them.

Test Plan:
- Reset then 800 cycles with pix_en=1:
  - hpos walks 0..799 then 0; vpos 0 -> 1 exactly at cycle 800.
  - line_tick high only at cycle 800.
- One full line:
  - hsync low exactly for hpos 656..751 (96 cycles).
  - display_on high exactly for hpos 0..639.
  - Both aligned with the reported hpos.
- Full frame (420000 cycles):
  - vsync low for vpos 490..491 (1600 cycles).
  - display_on never high for vpos >= 480.
  - frame_tick single pulse at hpos=0/vpos=0; frame_no 0 -> 1 in that same cycle.
- pix_en toggled 1,0,1 every cycle:
  - A line takes 1600 clk cycles.
  - line_tick still one cycle wide.
  - Outputs are stable during pix_en=0 cycles.
- Force frame_no to 511 via 512 frames (or FRAME_W=2, 4 frames): wraps to 0 with no glitch on the other outputs.
- Assert rst_n=0 at hpos=700, vpos=491 (both syncs active):
  - Next cycle hpos=0, vpos=0, hsync=vsync=1, frame_no=0, ticks 0.

Source files
------------

// File: rtl/vga_timing_core.sv
// vga_timing_core: free-running VGA raster timing generator.
// Flags are decoded from the next coordinates so they align with hpos/vpos.
module vga_timing_core #(
   parameter int H_DISPLAY   = 640,
   parameter int H_FRONT     = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int V_DISPLAY   = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter bit SYNC_ACTIVE = 1'b0,
   parameter int FRAME_W     = 9
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pix_en,
   output logic [9:0]         hpos,
   output logic [9:0]         vpos,
   output logic               hsync,
   output logic               vsync,
   output logic               display_on,
   output logic               line_tick,
   output logic               frame_tick,
   output logic [FRAME_W-1:0] frame_no
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024 ||
          H_TOTAL < 1 || V_TOTAL < 1) begin : g_bad_totals
         $error("vga_timing_core: raster totals must be 1..1024");
      end
   endgenerate

   localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   // 11-bit bounds: a sync end may sit exactly at 1024
   localparam logic [10:0] H_DE   = 11'(H_DISPLAY);
   localparam logic [10:0] HS_BEG = 11'(H_DISPLAY + H_FRONT);
   localparam logic [10:0] HS_END = 11'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [10:0] V_DE   = 11'(V_DISPLAY);
   localparam logic [10:0] VS_BEG = 11'(V_DISPLAY + V_FRONT);
   localparam logic [10:0] VS_END = 11'(V_DISPLAY + V_FRONT + V_SYNC);

   logic [9:0]         h_q;
   logic [9:0]         v_q;
   logic [9:0]         h_nxt;
   logic [9:0]         v_nxt;
   logic [10:0]        h_ext;
   logic [10:0]        v_ext;
   logic               h_wrap;
   logic               v_wrap;
   logic               hs_nxt;
   logic               vs_nxt;
   logic               de_nxt;
   logic               hs_q;
   logic               vs_q;
   logic               de_q;
   logic               lt_q;
   logic               ft_q;
   logic [FRAME_W-1:0] fn_q;

   always_comb begin
      h_wrap = (h_q == H_LAST);
      v_wrap = (v_q == V_LAST);
      h_nxt  = h_wrap ? 10'd0 : h_q + 10'd1;
      v_nxt  = v_q;
      if (h_wrap) begin
         v_nxt = v_wrap ? 10'd0 : v_q + 10'd1;
      end
      h_ext  = {1'b0, h_nxt};
      v_ext  = {1'b0, v_nxt};
      hs_nxt = (h_ext >= HS_BEG) && (h_ext < HS_END);
      vs_nxt = (v_ext >= VS_BEG) && (v_ext < VS_END);
      de_nxt = (h_ext < H_DE) && (v_ext < V_DE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h_q  <= '0;
         v_q  <= '0;
         hs_q <= ~SYNC_ACTIVE;
         vs_q <= ~SYNC_ACTIVE;
         de_q <= 1'b1;
         lt_q <= 1'b0;
         ft_q <= 1'b0;
         fn_q <= '0;
      end else if (pix_en) begin
         h_q  <= h_nxt;
         v_q  <= v_nxt;
         hs_q <= hs_nxt ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vs_q <= vs_nxt ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         de_q <= de_nxt;
         lt_q <= h_wrap;
         ft_q <= h_wrap & v_wrap;
         if (h_wrap && v_wrap) begin
            fn_q <= fn_q + FRAME_W'(1);
         end
      end else begin
         lt_q <= 1'b0;
         ft_q <= 1'b0;
      end
   end

   assign hpos       = h_q;
   assign vpos       = v_q;
   assign hsync      = hs_q;
   assign vsync      = vs_q;
   assign display_on = de_q;
   assign line_tick  = lt_q;
   assign frame_tick = ft_q;
   assign frame_no   = fn_q;

endmodule

// File: tb/tb_vga_timing_core.sv
// tb_vga_timing_core: vector table, pix_en toggling and random runs.
// Short vertical timing keeps whole frames cheap; horizontal is stock 800.
module tb_vga_timing_core;

   localparam int HT = 800;
   localparam int VT = 10;
   localparam int FT = HT * VT;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pix_en = 1'b0;
   logic [9:0] hpos;
   logic [9:0] vpos;
   logic       hsync;
   logic       vsync;
   logic       display_on;
   logic       line_tick;
   logic       frame_tick;
   logic [1:0] frame_no;

   vga_timing_core #(
      .H_DISPLAY(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
      .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .SYNC_ACTIVE(1'b0), .FRAME_W(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
      .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
      .display_on(display_on), .line_tick(line_tick),
      .frame_tick(frame_tick), .frame_no(frame_no)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic        e;
      int          n;
      logic [26:0] exp;
   } vec_t;

   vec_t  tbl[19];
   int    checks = 0;
   int    errors = 0;
   longint t = 0;
   bit    adv = 1'b0;

   function automatic logic [26:0] pack(input int h, input int v,
      input int hs, input int vs, input int de, input int lt,
      input int ft, input int fn);
      return {10'(h), 10'(v), 1'(hs), 1'(vs), 1'(de),
              1'(lt), 1'(ft), 2'(fn)};
   endfunction

   function automatic vec_t mk(input int r, input int e, input int n,
      input logic [26:0] x);
      vec_t o;
      o.r = 1'(r);
      o.e = 1'(e);
      o.n = n;
      o.exp = x;
      return o;
   endfunction

   function automatic logic [26:0] got();
      return {hpos, vpos, hsync, vsync, display_on,
              line_tick, frame_tick, frame_no};
   endfunction

   // reference: everything derives from the count of enabled advances
   function automatic logic [26:0] model();
      int h, v, fn, lt;
      h  = int'(t % HT);
      v  = int'((t / HT) % VT);
      fn = int'((t / FT) % 4);
      lt = (adv && h == 0) ? 1 : 0;
      return pack(h, v, (h >= 656 && h < 752) ? 0 : 1,
                  (v >= 7 && v < 9) ? 0 : 1,
                  (h < 640 && v < 6) ? 1 : 0,
                  lt, (lt == 1 && v == 0) ? 1 : 0, fn);
   endfunction

   task automatic step(input logic r, input logic e);
      rst_n = r;
      pix_en = e;
      @(posedge clk);
      #1;
      if (!r) begin
         t = 0;
         adv = 1'b0;
      end else if (e) begin
         t++;
         adv = 1'b1;
      end else begin
         adv = 1'b0;
      end
   endtask

   task automatic cmp(input string nm, input logic [26:0] exp);
      checks++;
      if (got() !== exp) begin
         errors++;
         $display("FAIL %s t=%0d got=%h want=%h", nm, t, got(), exp);
      end
   endtask

   int lt_cnt;
   int lt_at[$];

   initial begin
      tbl[0]  = mk(0, 1, 1,     pack(0, 0, 1, 1, 1, 0, 0, 0));
      tbl[1]  = mk(1, 0, 5,     pack(0, 0, 1, 1, 1, 0, 0, 0));
      tbl[2]  = mk(1, 1, 1,     pack(1, 0, 1, 1, 1, 0, 0, 0));
      tbl[3]  = mk(1, 1, 638,   pack(639, 0, 1, 1, 1, 0, 0, 0));
      tbl[4]  = mk(1, 1, 1,     pack(640, 0, 1, 1, 0, 0, 0, 0));
      tbl[5]  = mk(1, 1, 16,    pack(656, 0, 0, 1, 0, 0, 0, 0));
      tbl[6]  = mk(1, 1, 95,    pack(751, 0, 0, 1, 0, 0, 0, 0));
      tbl[7]  = mk(1, 1, 1,     pack(752, 0, 1, 1, 0, 0, 0, 0));
      tbl[8]  = mk(1, 1, 47,    pack(799, 0, 1, 1, 0, 0, 0, 0));
      tbl[9]  = mk(1, 1, 1,     pack(0, 1, 1, 1, 1, 1, 0, 0));
      tbl[10] = mk(1, 1, 1,     pack(1, 1, 1, 1, 1, 0, 0, 0));
      tbl[11] = mk(1, 0, 3,     pack(1, 1, 1, 1, 1, 0, 0, 0));
      tbl[12] = mk(1, 1, 4799,  pack(0, 7, 1, 0, 0, 1, 0, 0));
      tbl[13] = mk(1, 1, 700,   pack(700, 7, 0, 0, 0, 0, 0, 0));
      tbl[14] = mk(1, 1, 800,   pack(700, 8, 0, 0, 0, 0, 0, 0));
      tbl[15] = mk(0, 1, 1,     pack(0, 0, 1, 1, 1, 0, 0, 0));
      tbl[16] = mk(1, 1, 8000,  pack(0, 0, 1, 1, 1, 1, 1, 1));
      tbl[17] = mk(1, 1, 1,     pack(1, 0, 1, 1, 1, 0, 0, 1));
      tbl[18] = mk(1, 1, 23999, pack(0, 0, 1, 1, 1, 1, 1, 0));

      step(1'b0, 1'b0);
      for (int i = 0; i < 19; i++) begin
         for (int k = 0; k < tbl[i].n; k++) begin
            step(tbl[i].r, tbl[i].e);
         end
         cmp($sformatf("vec%0d", i), tbl[i].exp);
      end

      // pix_en alternating: a line costs 1600 clocks
      step(1'b0, 1'b0);
      lt_at.delete();
      for (int i = 0; i < 3300; i++) begin
         step(1'b1, (i % 2) == 0);
         cmp("toggle", model());
         if (line_tick) lt_at.push_back(i);
      end
      lt_cnt = lt_at.size();
      checks++;
      if (lt_cnt != 2) begin
         errors++;
         $display("FAIL tick_count got=%0d want=2", lt_cnt);
      end else begin
         checks++;
         if (lt_at[1] - lt_at[0] != 1600) begin
            errors++;
            $display("FAIL tick_gap got=%0d want=1600",
                     lt_at[1] - lt_at[0]);
         end
      end

      step(1'b0, 1'b1);
      cmp("rnd_reset", model());
      for (int i = 0; i < 15000; i++) begin
         step($urandom_range(0, 999) != 0, $urandom_range(0, 3) != 0);
         cmp("random", model());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
